// File: rtl/pwm_decoder.sv
// PWM line decoder: recovers duty and frame period from a sampled PWM input.
// Define PWM_DECODER_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizer.
module pwm_decoder #(
    parameter int PWM_IN_SIZE = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pwm_in,
    output logic [PWM_IN_SIZE-1:0] data_out,
    output logic [PWM_IN_SIZE+1:0] period_out,
    output logic                   data_valid,
    output logic                   stuck,
    output logic                   period_err
);

    localparam int N = PWM_IN_SIZE;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [N+1:0] PER_ZERO    = {(N+2){1'b0}};
    localparam logic [N+1:0] PER_ONE     = {{(N+1){1'b0}}, 1'b1};
    localparam logic [N+1:0] PER_NOMINAL = {2'b01, {N{1'b0}}};
    localparam logic [N+1:0] PER_TIMEOUT = {2'b10, {N{1'b0}}};
    localparam logic [N+1:0] PER_MAX     = {(N+2){1'b1}};
    localparam logic [N:0]   HIGH_ZERO   = {(N+1){1'b0}};
    localparam logic [N:0]   HIGH_ONE    = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   HIGH_MAX    = {(N+1){1'b1}};
    localparam logic [N-1:0] DUTY_MAX    = {N{1'b1}};
    localparam logic [N-1:0] DUTY_ZERO   = {N{1'b0}};

    logic           sync1_r;
    logic           sync2_r;
    logic           s_s;
    logic           s_prev_r;
    logic           rise_s;
    logic [0:0]     state_r;
    logic [0:0]     state_n_s;
    logic [N+1:0]   per_cnt_r;
    logic [N+1:0]   per_cnt_n_s;
    logic [N:0]     high_cnt_r;
    logic [N:0]     high_cnt_n_s;
    logic [N-1:0]   data_out_r;
    logic [N-1:0]   data_out_n_s;
    logic [N+1:0]   period_out_r;
    logic [N+1:0]   period_out_n_s;
    logic           data_valid_r;
    logic           data_valid_n_s;
    logic           stuck_r;
    logic           stuck_n_s;
    logic           period_err_r;
    logic           period_err_n_s;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic hist1_r;
    logic hist2_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-deep history of synchronized samples feeding the majority vote
    always_ff @(posedge clk) begin
        if (reset) begin
            hist1_r <= 1'b0;
            hist2_r <= 1'b0;
        end else begin
            hist1_r <= sync2_r;
            hist2_r <= hist1_r;
        end
    end

    assign s_s = maj3(sync2_r, hist1_r, hist2_r);
`else
    assign s_s = sync2_r;
`endif

    // Metastability synchronizer and edge-detect register; run regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            s_prev_r <= 1'b0;
        end else begin
            sync1_r  <= pwm_in;
            sync2_r  <= sync1_r;
            s_prev_r <= s_s;
        end
    end

    assign rise_s = s_s & ~s_prev_r;

    // Next-state logic: frame measurement, report on rise, stuck timeout
    always_comb begin
        state_n_s      = state_r;
        per_cnt_n_s    = per_cnt_r;
        high_cnt_n_s   = high_cnt_r;
        data_out_n_s   = data_out_r;
        period_out_n_s = period_out_r;
        period_err_n_s = period_err_r;
        stuck_n_s      = stuck_r;
        data_valid_n_s = 1'b0;
        if (!enable) begin
            state_n_s    = ST_IDLE;
            per_cnt_n_s  = PER_ZERO;
            high_cnt_n_s = HIGH_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The first rise only arms; the partial frame before it is discarded
                    if (rise_s) begin
                        state_n_s    = ST_MEASURE;
                        per_cnt_n_s  = PER_ONE;
                        high_cnt_n_s = HIGH_ONE;
                        stuck_n_s    = 1'b0;
                    end else begin
                        state_n_s    = ST_IDLE;
                        per_cnt_n_s  = PER_ZERO;
                        high_cnt_n_s = HIGH_ZERO;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        data_out_n_s   = (high_cnt_r > {1'b0, DUTY_MAX}) ? DUTY_MAX : high_cnt_r[N-1:0];
                        period_out_n_s = per_cnt_r;
                        period_err_n_s = (per_cnt_r != PER_NOMINAL);
                        data_valid_n_s = 1'b1;
                        stuck_n_s      = 1'b0;
                        per_cnt_n_s    = PER_ONE;
                        high_cnt_n_s   = HIGH_ONE;
                    end else if (per_cnt_r == PER_TIMEOUT) begin
                        data_out_n_s   = s_s ? DUTY_MAX : DUTY_ZERO;
                        period_out_n_s = PER_ZERO;
                        period_err_n_s = 1'b1;
                        stuck_n_s      = 1'b1;
                        data_valid_n_s = 1'b1;
                        state_n_s      = ST_IDLE;
                        per_cnt_n_s    = PER_ZERO;
                        high_cnt_n_s   = HIGH_ZERO;
                    end else begin
                        per_cnt_n_s  = (per_cnt_r == PER_MAX) ? PER_MAX : (per_cnt_r + PER_ONE);
                        high_cnt_n_s = (s_s && (high_cnt_r != HIGH_MAX)) ? (high_cnt_r + HIGH_ONE) : high_cnt_r;
                    end
                end
                default: begin
                    state_n_s    = ST_IDLE;
                    per_cnt_n_s  = PER_ZERO;
                    high_cnt_n_s = HIGH_ZERO;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            per_cnt_r    <= PER_ZERO;
            high_cnt_r   <= HIGH_ZERO;
            data_out_r   <= DUTY_ZERO;
            period_out_r <= PER_ZERO;
            period_err_r <= 1'b0;
            stuck_r      <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            per_cnt_r    <= per_cnt_n_s;
            high_cnt_r   <= high_cnt_n_s;
            data_out_r   <= data_out_n_s;
            period_out_r <= period_out_n_s;
            period_err_r <= period_err_n_s;
            stuck_r      <= stuck_n_s;
            data_valid_r <= data_valid_n_s;
        end
    end

    assign data_out   = data_out_r;
    assign period_out = period_out_r;
    assign data_valid = data_valid_r;
    assign stuck      = stuck_r;
    assign period_err = period_err_r;

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart of the unsigned PWM generator: samples a single-bit PWM line, recovers the duty value the generator was driven with, and measures the frame period. Sits on the input side of the pendulum-mimicker datapath, closing the loop on generator output for self-check and decoding externally supplied PWM. Issues one `data_valid` strobe per complete frame and flags stuck lines and off-nominal periods.

## Interface
- `PWM_IN_SIZE`, default 4: duty resolution N; nominal frame = 2^N clocks.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  decode enable; low forces IDLE.
- `pwm_in`  in  1  asynchronous PWM line.
- `data_out`  out  N  recovered duty (high-clock count), saturated at 2^N-1.
- `period_out`  out  N+2  measured frame length in clocks; 0 on stuck report.
- `data_valid`  out  1  one-cycle strobe when `data_out`/`period_out` update.
- `stuck`  out  1  no rising edge within timeout; cleared on next rising edge.
- `period_err`  out  1  last reported `period_out` != 2^N.

## Operation
- Input path: 2-flop synchronizer (reset to 0), then edge-detect register; `s` = conditioned sample, rise = `s` & !`s_prev`.
- Counters: `per_cnt` N+2 bits saturating at 2^(N+2)-1; `high_cnt` N+1 bits saturating at 2^(N+1)-1.
- States: IDLE, MEASURE.
- IDLE: counters held at 0. On rise -> MEASURE, `per_cnt`=1, `high_cnt`=1, no strobe (partial frame discarded), `stuck`<=0.
- MEASURE, rise: `data_out`<=min(`high_cnt`, 2^N-1); `period_out`<=`per_cnt`; `period_err`<=(`per_cnt`!=2^N); `data_valid`<=1; then `per_cnt`=1, `high_cnt`=1.
- MEASURE, no rise: `per_cnt`+=1, `high_cnt`+=`s`.
- Timeout: in MEASURE with `per_cnt`==2^(N+1) and no rise -> `data_out`<= `s` ? 2^N-1 : 0; `period_out`<=0; `period_err`<=1; `stuck`<=1; `data_valid`<=1; -> IDLE. Exactly one report per stuck episode.
- `enable` low: -> IDLE, counters cleared, `data_valid`=0, other outputs hold. Re-enable needs a fresh rise plus one full frame before first strobe.
- Rise and timeout same cycle: rise wins.

## Timing
- Reset values: `data_out`=0, `period_out`=0, `data_valid`=0, `stuck`=0, `period_err`=0, state IDLE, synchronizer/edge regs 0.
- `pwm_in` to `s`: 2 clocks (3 with filter). A line already high at reset release produces a rise; treated as IDLE arm only.
- Strobe occurs the cycle after the rise sample of frame k+1 is registered; outputs valid on and after the strobe, stable until next strobe.
- Generator at 2^N frame: one strobe per 2^N clocks, steady-state.
- Mid-frame `reset`: all state to reset values next edge; no strobe for the interrupted frame.

## Configuration
- `PWM_DECODER_GLITCH_FILTER_EN` defined: 3-sample majority vote after the synchronizer; `s` = maj(last three). Adds 1 clock latency to both edges (duty unchanged); single-clock glitches rejected; pulses <2 clocks not decoded.
- Undefined: `s` = synchronizer output directly; every sampled transition counts.

## Test plan
- N=4, generator data_in=1, 3 frames -> strobes every 16 clocks, `data_out`=1, `period_out`=16, `period_err`=0 after first full frame.
- data_in=8 then 15 -> `data_out`=8 then 15, `period_out`=16; transition frame may report intermediate value once only.
- `pwm_in` held 0 for 40 clocks after valid frames -> single strobe at `per_cnt`=32, `data_out`=0, `period_out`=0, `stuck`=1; next rise clears `stuck`, no strobe.
- Held 1 after a rise -> timeout strobe, `data_out`=15, `stuck`=1.
- Frame of 20 clocks, 6 high -> `data_out`=6, `period_out`=20, `period_err`=1.
- `reset` asserted mid-frame then `enable` toggled -> all outputs 0, first strobe only after arm rise plus a full frame; with filter macro, 1-clock glitch mid-high yields unchanged `data_out`.
